rf_wb_arbiter: RTL and testbench

Drives the single register-file write port from two sources. The first is the main pipeline WB stage, which has priority and is never stalled. The second is a long-latency result source (divider, uncached load return) that connects through a valid/ready handshake and a 2-entry buffer. The block sits between WB and the register file. It also supplies ID-stage forwarding for writes that have been accepted but are not yet committed to the register file.

---
 rtl/rf_wb_arbiter.sv | 104 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: the pipeline WB write has priority, long-latency
// results queue in a 2-entry buffer, and pending writes are forwarded to ID.
module rf_wb_arbiter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        Pipe_Wr,
    input  logic [4:0]  Pipe_Dst,
    input  logic [31:0] Pipe_Result,
    input  logic        Lu_Valid,
    output logic        Lu_Ready,
    input  logic [4:0]  Lu_Dst,
    input  logic [31:0] Lu_Result,
    output logic        RFWr,
    output logic [4:0]  WB_Dst,
    output logic [31:0] WB_Result,
    output logic        Busy,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    output logic        FwdA_Hit,
    output logic        FwdB_Hit,
    output logic [31:0] FwdA_Data,
    output logic [31:0] FwdB_Data
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  idx;
        logic [31:0] data;
    } entry_t;

    entry_t     buf_q [2];
    logic       head;
    logic       tail;
    logic [1:0] count;

    logic pipe_sel;
    logic accept;
    logic enq;
    logic pop;

    assign Lu_Ready = (count != 2'd2);
    assign Busy     = (count != 2'd0);
    assign pipe_sel = Pipe_Wr && (Pipe_Dst != 5'd0);
    assign accept   = Lu_Valid && Lu_Ready;
    // A same-cycle pipe write to the same register is younger, so the long result is dropped.
    assign enq      = accept && (Lu_Dst != 5'd0) && !(Pipe_Wr && (Lu_Dst == Pipe_Dst));
    assign pop      = !pipe_sel && (count != 2'd0);

    function automatic logic [32:0] lookup(
        input logic [4:0]  src,
        input entry_t      young,
        input entry_t      old,
        input logic        wr,
        input logic [4:0]  dst,
        input logic [31:0] res
    );
        if (src == 5'd0)                      return '0;
        if (young.valid && young.idx == src)  return {1'b1, young.data};
        if (old.valid && old.idx == src)      return {1'b1, old.data};
        if (wr && dst == src)                 return {1'b1, res};
        return '0;
    endfunction

    // The slot behind tail is the youngest entry; the slot at tail is the older one when full.
    assign {FwdA_Hit, FwdA_Data} = lookup(ID_rs, buf_q[~tail], buf_q[tail], RFWr, WB_Dst, WB_Result);
    assign {FwdB_Hit, FwdB_Data} = lookup(ID_rt, buf_q[~tail], buf_q[tail], RFWr, WB_Dst, WB_Result);

    // NOTE: all state below uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the buffer is two flop entries, so it is reset to guarantee clear valid bits.
            for (int i = 0; i < 2; i++) buf_q[i] <= '0;
            head      <= 1'b0;
            tail      <= 1'b0;
            count     <= 2'd0;
            RFWr      <= 1'b0;
            WB_Dst    <= 5'd0;
            WB_Result <= 32'd0;
        end else begin
            if (pipe_sel) begin
                RFWr      <= 1'b1;
                WB_Dst    <= Pipe_Dst;
                WB_Result <= Pipe_Result;
                for (int i = 0; i < 2; i++)
                    if (buf_q[i].idx == Pipe_Dst) buf_q[i].valid <= 1'b0;
            end else if (pop) begin
                RFWr            <= buf_q[head].valid;
                WB_Dst          <= buf_q[head].idx;
                WB_Result       <= buf_q[head].data;
                buf_q[head].valid <= 1'b0;
                head            <= ~head;
            end else begin
                RFWr <= 1'b0;
            end
            // Placed after the kill loop so a fresh entry in a stale slot keeps valid=1.
            if (enq) begin
                buf_q[tail] <= '{valid: 1'b1, idx: Lu_Dst, data: Lu_Result};
                tail        <= ~tail;
            end
            count <= count + 2'(enq) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pipe_wr;
    logic [4:0]  pipe_dst;
    logic [31:0] pipe_result;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_dst;
    logic [31:0] lu_result;
    logic        rfwr;
    logic [4:0]  wb_dst;
    logic [31:0] wb_result;
    logic        busy;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        fwda_hit;
    logic        fwdb_hit;
    logic [31:0] fwda_data;
    logic [31:0] fwdb_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk(clk), .resetn(resetn),
        .Pipe_Wr(pipe_wr), .Pipe_Dst(pipe_dst), .Pipe_Result(pipe_result),
        .Lu_Valid(lu_valid), .Lu_Ready(lu_ready), .Lu_Dst(lu_dst), .Lu_Result(lu_result),
        .RFWr(rfwr), .WB_Dst(wb_dst), .WB_Result(wb_result), .Busy(busy),
        .ID_rs(id_rs), .ID_rt(id_rt),
        .FwdA_Hit(fwda_hit), .FwdB_Hit(fwdb_hit), .FwdA_Data(fwda_data), .FwdB_Data(fwdb_data)
    );

    // Reference model: pending writes in program order, oldest at the front.
    typedef struct {
        bit          v;
        logic [4:0]  d;
        logic [31:0] r;
    } ment_t;

    ment_t       mq[$];
    bit          m_rfwr;
    logic [4:0]  m_dst;
    logic [31:0] m_res;

    task automatic model_reset();
        mq.delete();
        m_rfwr = 0;
        m_dst  = '0;
        m_res  = '0;
    endtask

    task automatic model_step();
        bit    ready;
        bit    pipe;
        bit    keep;
        ment_t e;
        ready = (mq.size() < 2);
        pipe  = pipe_wr && (pipe_dst != 0);
        keep  = lu_valid && ready && (lu_dst != 0) && !(pipe_wr && lu_dst == pipe_dst);
        if (pipe) begin
            m_rfwr = 1;
            m_dst  = pipe_dst;
            m_res  = pipe_result;
            foreach (mq[i]) if (mq[i].d == pipe_dst) mq[i].v = 0;
        end else if (mq.size() > 0) begin
            e      = mq.pop_front();
            m_rfwr = e.v;
            m_dst  = e.d;
            m_res  = e.r;
        end else begin
            m_rfwr = 0;
        end
        if (keep) mq.push_back('{v: 1, d: lu_dst, r: lu_result});
    endtask

    task automatic model_fwd(input logic [4:0] src, output bit hit, output logic [31:0] data);
        hit  = 0;
        data = '0;
        if (src == 0) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].v && mq[i].d == src) begin
                hit  = 1;
                data = mq[i].r;
                return;
            end
        end
        if (m_rfwr && m_dst == src) begin
            hit  = 1;
            data = m_res;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!resetn) model_reset();
        else         model_step();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        resetn = 0;
        pipe_wr = 1; pipe_dst = 5; pipe_result = 32'hDEAD0005;
        lu_valid = 0; lu_dst = 0; lu_result = 0;
        id_rs = 5; id_rt = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (rfwr !== 1'b0) begin n_fail++; $display("FAIL reset_rfwr cyc%0d: got %b want 0", c, rfwr); end
            n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready cyc%0d: got %b want 1", c, lu_ready); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy cyc%0d: got %b want 0", c, busy); end
        end
        n_checks++; if (wb_dst !== 5'd0 || wb_result !== 32'd0) begin n_fail++; $display("FAIL reset_wb: got %0d/%h want 0/0", wb_dst, wb_result); end
        n_checks++; if (fwda_hit !== 1'b0 || fwda_data !== 32'd0) begin n_fail++; $display("FAIL reset_fwd: got %b/%h want 0/0", fwda_hit, fwda_data); end
        resetn = 1;
        tick();
        n_checks++; if (rfwr !== 1'b1 || wb_dst !== 5'd5 || wb_result !== 32'hDEAD0005) begin
            n_fail++; $display("FAIL reset_release: got %b/%0d/%h want 1/5/dead0005", rfwr, wb_dst, wb_result); end
    endtask

    task automatic test_priority();
        pipe_wr = 1; pipe_dst = 3; pipe_result = 32'hAAAA0000;
        lu_valid = 1; lu_dst = 7; lu_result = 32'h12345678;
        tick();
        n_checks++; if (rfwr !== 1'b1 || wb_dst !== 5'd3 || wb_result !== 32'hAAAA0000) begin
            n_fail++; $display("FAIL prio_pipe: got %b/%0d/%h want 1/3/aaaa0000", rfwr, wb_dst, wb_result); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL prio_busy: got %b want 1", busy); end
        pipe_wr = 0; lu_valid = 0; id_rs = 7; #1;
        n_checks++; if (fwda_hit !== 1'b1 || fwda_data !== 32'h12345678) begin
            n_fail++; $display("FAIL prio_fwd: got %b/%h want 1/12345678", fwda_hit, fwda_data); end
        tick();
        n_checks++; if (rfwr !== 1'b1 || wb_dst !== 5'd7 || wb_result !== 32'h12345678) begin
            n_fail++; $display("FAIL prio_lu: got %b/%0d/%h want 1/7/12345678", rfwr, wb_dst, wb_result); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_drained: got %b want 0", busy); end
    endtask

    task automatic test_full();
        pipe_wr = 1; pipe_dst = 1; pipe_result = 32'h100;
        lu_valid = 1; lu_dst = 8; lu_result = 32'h88;
        tick();
        lu_dst = 9; lu_result = 32'h99;
        tick();
        n_checks++; if (lu_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL full_state: got ready=%b busy=%b want 0/1", lu_ready, busy); end
        lu_dst = 11; lu_result = 32'hBB;
        tick();
        n_checks++; if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold: got %b want 0", lu_ready); end
        pipe_wr = 0; lu_valid = 0;
        tick();
        n_checks++; if (rfwr !== 1'b1 || wb_dst !== 5'd8 || wb_result !== 32'h88) begin
            n_fail++; $display("FAIL full_pop8: got %b/%0d/%h want 1/8/88", rfwr, wb_dst, wb_result); end
        n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_back: got %b want 1", lu_ready); end
        tick();
        n_checks++; if (rfwr !== 1'b1 || wb_dst !== 5'd9 || wb_result !== 32'h99) begin
            n_fail++; $display("FAIL full_pop9: got %b/%0d/%h want 1/9/99", rfwr, wb_dst, wb_result); end
        tick();
        n_checks++; if (rfwr !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL full_no_r11: got rfwr=%b busy=%b want 0/0", rfwr, busy); end
    endtask

    task automatic test_kill();
        pipe_wr = 0; lu_valid = 1; lu_dst = 10; lu_result = 32'h1;
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL kill_enq: got %b want 1", busy); end
        pipe_wr = 1; pipe_dst = 10; pipe_result = 32'h2; lu_valid = 0;
        tick();
        n_checks++; if (rfwr !== 1'b1 || wb_dst !== 5'd10 || wb_result !== 32'h2) begin
            n_fail++; $display("FAIL kill_pipe: got %b/%0d/%h want 1/10/2", rfwr, wb_dst, wb_result); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL kill_slot: got %b want 1", busy); end
        pipe_wr = 0; id_rs = 10; #1;
        n_checks++; if (fwda_hit !== 1'b1 || fwda_data !== 32'h2) begin
            n_fail++; $display("FAIL kill_fwd: got %b/%h want 1/2", fwda_hit, fwda_data); end
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++; if (rfwr !== 1'b0) begin n_fail++; $display("FAIL kill_bubble cyc%0d: got %b want 0", c, rfwr); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_drained: got %b want 0", busy); end
    endtask

    task automatic test_zero();
        pipe_wr = 1; pipe_dst = 0; pipe_result = 32'h55;
        lu_valid = 1; lu_dst = 0; lu_result = 32'h66;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (rfwr !== 1'b0 || busy !== 1'b0 || lu_ready !== 1'b1) begin
                n_fail++; $display("FAIL zero cyc%0d: got rfwr=%b busy=%b ready=%b want 0/0/1", c, rfwr, busy, lu_ready); end
        end
    endtask

    task automatic test_forward();
        pipe_wr = 1; pipe_dst = 1; pipe_result = 32'h777;
        lu_valid = 1; lu_dst = 4; lu_result = 32'h11;
        tick();
        lu_result = 32'h22;
        tick();
        lu_valid = 0; id_rs = 4; id_rt = 0; #1;
        n_checks++; if (fwda_hit !== 1'b1 || fwda_data !== 32'h22) begin
            n_fail++; $display("FAIL fwd_young: got %b/%h want 1/22", fwda_hit, fwda_data); end
        n_checks++; if (fwdb_hit !== 1'b0 || fwdb_data !== 32'h0) begin
            n_fail++; $display("FAIL fwd_r0: got %b/%h want 0/0", fwdb_hit, fwdb_data); end
        id_rt = 1; #1;
        n_checks++; if (fwdb_hit !== 1'b1 || fwdb_data !== 32'h777) begin
            n_fail++; $display("FAIL fwd_outreg: got %b/%h want 1/777", fwdb_hit, fwdb_data); end
        pipe_wr = 0;
        tick();
        n_checks++; if (rfwr !== 1'b1 || wb_dst !== 5'd4 || wb_result !== 32'h11) begin
            n_fail++; $display("FAIL fwd_pop_old: got %b/%0d/%h want 1/4/11", rfwr, wb_dst, wb_result); end
        n_checks++; if (fwda_data !== 32'h22) begin n_fail++; $display("FAIL fwd_buf_over_out: got %h want 22", fwda_data); end
        tick();
        n_checks++; if (rfwr !== 1'b1 || wb_result !== 32'h22 || fwda_hit !== 1'b1 || fwda_data !== 32'h22) begin
            n_fail++; $display("FAIL fwd_pop_young: got %b/%h fwd %b/%h want 1/22 1/22", rfwr, wb_result, fwda_hit, fwda_data); end
    endtask

    task automatic test_midreset();
        pipe_wr = 1; pipe_dst = 2; pipe_result = 32'h3;
        lu_valid = 1; lu_dst = 6; lu_result = 32'h4;
        tick();
        resetn = 0; #1;
        model_reset();
        n_checks++; if (rfwr !== 1'b0 || busy !== 1'b0 || lu_ready !== 1'b1 || wb_dst !== 5'd0) begin
            n_fail++; $display("FAIL midreset: got rfwr=%b busy=%b ready=%b dst=%0d want 0/0/1/0", rfwr, busy, lu_ready, wb_dst); end
        tick();
        resetn = 1; pipe_wr = 0; lu_valid = 0;
        tick();
        n_checks++; if (rfwr !== 1'b0) begin n_fail++; $display("FAIL midreset_flush: got %b want 0", rfwr); end
    endtask

    task automatic test_random();
        bit          ehit_a, ehit_b;
        logic [31:0] edata_a, edata_b;
        for (int c = 0; c < 1500; c++) begin
            pipe_wr     = ($urandom_range(0, 99) < 40);
            pipe_dst    = 5'($urandom_range(0, 7));
            pipe_result = $urandom;
            lu_valid    = ($urandom_range(0, 99) < 60);
            lu_dst      = 5'($urandom_range(0, 7));
            lu_result   = $urandom;
            id_rs       = 5'($urandom_range(0, 7));
            id_rt       = 5'($urandom_range(0, 7));
            #1;
            model_fwd(id_rs, ehit_a, edata_a);
            model_fwd(id_rt, ehit_b, edata_b);
            n_checks++; if (fwda_hit !== ehit_a || fwda_data !== edata_a) begin
                n_fail++; $display("FAIL rnd_fwda cyc%0d: got %b/%h want %b/%h", c, fwda_hit, fwda_data, ehit_a, edata_a); end
            n_checks++; if (fwdb_hit !== ehit_b || fwdb_data !== edata_b) begin
                n_fail++; $display("FAIL rnd_fwdb cyc%0d: got %b/%h want %b/%h", c, fwdb_hit, fwdb_data, ehit_b, edata_b); end
            n_checks++; if (lu_ready !== (mq.size() < 2) || busy !== (mq.size() != 0)) begin
                n_fail++; $display("FAIL rnd_flags cyc%0d: got ready=%b busy=%b want depth %0d", c, lu_ready, busy, mq.size()); end
            tick();
            n_checks++; if (rfwr !== m_rfwr || wb_dst !== m_dst || wb_result !== m_res) begin
                n_fail++; $display("FAIL rnd_wb cyc%0d: got %b/%0d/%h want %b/%0d/%h", c, rfwr, wb_dst, wb_result, m_rfwr, m_dst, m_res); end
            if ($urandom_range(0, 199) == 0) begin
                resetn = 0; #1;
                model_reset();
                n_checks++; if (rfwr !== 1'b0 || busy !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_reset cyc%0d: got rfwr=%b busy=%b want 0/0", c, rfwr, busy); end
                resetn = 1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_full();
        test_kill();
        test_zero();
        test_forward();
        test_midreset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
